// File: rtl/instr_decode_stage_pkg.sv
//==============================================================================
// Package : instr_decode_stage_pkg
// Brief   : Instruction encoding shared by the core and its decode stage.
//           Holds the instruction/op types, the mask/match table, the decoded
//           record and the encode helpers.
// Rev     : 1.0 - initial release
//==============================================================================
`default_nettype none

package instr_decode_stage_pkg;

    localparam int c_XLEN = 32;
    localparam int c_PC_W = 32;

    typedef logic [31:0] instruction_t;

    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] c_F7_BASE   = 7'h00;
    localparam logic [6:0] c_F7_ALT    = 7'h20;
    localparam logic [6:0] c_F7_MULDIV = 7'h01;

    localparam instruction_t c_MASK_OPC = 32'h0000_007F;
    localparam instruction_t c_MASK_F3  = 32'h0000_707F;
    localparam instruction_t c_MASK_F7  = 32'hFE00_707F;
    localparam instruction_t c_MASK_ALL = 32'hFFFF_FFFF;

    localparam instruction_t HALT = 32'h0010_0073;

    typedef enum logic [5:0] {
        M_LUI, M_AUIPC, M_JAL, M_JALR,
        M_BEQ, M_BNE, M_BLT, M_BGE, M_BLTU, M_BGEU,
        M_LB, M_LH, M_LW, M_LBU, M_LHU,
        M_SB, M_SH, M_SW,
        M_ADDI, M_SLTI, M_SLTIU, M_XORI, M_ORI, M_ANDI, M_SLLI, M_SRLI, M_SRAI,
        M_ADD, M_SUB, M_SLL, M_SLT, M_SLTU, M_XOR, M_SRL, M_SRA, M_OR, M_AND,
        M_MUL, M_MULH, M_MULHSU, M_MULHU, M_DIV, M_DIVU, M_REM, M_REMU,
        M_HALT,
        M_ILLEGAL
    } opcode_mask_t;

    // Unknown major opcodes fall back to FMT_R so their fields are still exposed.
    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} instr_fmt_e;

    typedef struct packed {
        opcode_mask_t        op;
        instr_fmt_e          fmt;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [c_XLEN-1:0]   imm;
        logic [c_PC_W-1:0]   pc;
        logic                illegal;
        logic                halt;
    } decoded_instr_t;

    typedef struct packed {
        instruction_t mask;
        instruction_t match;
    } op_pattern_t;

    function automatic op_pattern_t pf(input instruction_t mask, input logic [6:0] f7,
                                       input logic [2:0] f3, input logic [6:0] opc);
        op_pattern_t p;
        p.mask  = mask;
        p.match = {f7, 10'b0, f3, 5'b0, opc} & mask;
        return p;
    endfunction

    // M_ILLEGAL gets an unmatchable pattern (mask 0, match 1).
    function automatic op_pattern_t op_pattern(input opcode_mask_t op);
        op_pattern_t p;
        case (op)
            M_LUI:    p = pf(c_MASK_OPC, c_F7_BASE, 3'd0, c_OPC_LUI);
            M_AUIPC:  p = pf(c_MASK_OPC, c_F7_BASE, 3'd0, c_OPC_AUIPC);
            M_JAL:    p = pf(c_MASK_OPC, c_F7_BASE, 3'd0, c_OPC_JAL);
            M_JALR:   p = pf(c_MASK_F3,  c_F7_BASE, 3'd0, c_OPC_JALR);
            M_BEQ:    p = pf(c_MASK_F3,  c_F7_BASE, 3'd0, c_OPC_BRANCH);
            M_BNE:    p = pf(c_MASK_F3,  c_F7_BASE, 3'd1, c_OPC_BRANCH);
            M_BLT:    p = pf(c_MASK_F3,  c_F7_BASE, 3'd4, c_OPC_BRANCH);
            M_BGE:    p = pf(c_MASK_F3,  c_F7_BASE, 3'd5, c_OPC_BRANCH);
            M_BLTU:   p = pf(c_MASK_F3,  c_F7_BASE, 3'd6, c_OPC_BRANCH);
            M_BGEU:   p = pf(c_MASK_F3,  c_F7_BASE, 3'd7, c_OPC_BRANCH);
            M_LB:     p = pf(c_MASK_F3,  c_F7_BASE, 3'd0, c_OPC_LOAD);
            M_LH:     p = pf(c_MASK_F3,  c_F7_BASE, 3'd1, c_OPC_LOAD);
            M_LW:     p = pf(c_MASK_F3,  c_F7_BASE, 3'd2, c_OPC_LOAD);
            M_LBU:    p = pf(c_MASK_F3,  c_F7_BASE, 3'd4, c_OPC_LOAD);
            M_LHU:    p = pf(c_MASK_F3,  c_F7_BASE, 3'd5, c_OPC_LOAD);
            M_SB:     p = pf(c_MASK_F3,  c_F7_BASE, 3'd0, c_OPC_STORE);
            M_SH:     p = pf(c_MASK_F3,  c_F7_BASE, 3'd1, c_OPC_STORE);
            M_SW:     p = pf(c_MASK_F3,  c_F7_BASE, 3'd2, c_OPC_STORE);
            M_ADDI:   p = pf(c_MASK_F3,  c_F7_BASE, 3'd0, c_OPC_OP_IMM);
            M_SLTI:   p = pf(c_MASK_F3,  c_F7_BASE, 3'd2, c_OPC_OP_IMM);
            M_SLTIU:  p = pf(c_MASK_F3,  c_F7_BASE, 3'd3, c_OPC_OP_IMM);
            M_XORI:   p = pf(c_MASK_F3,  c_F7_BASE, 3'd4, c_OPC_OP_IMM);
            M_ORI:    p = pf(c_MASK_F3,  c_F7_BASE, 3'd6, c_OPC_OP_IMM);
            M_ANDI:   p = pf(c_MASK_F3,  c_F7_BASE, 3'd7, c_OPC_OP_IMM);
            M_SLLI:   p = pf(c_MASK_F7,  c_F7_BASE, 3'd1, c_OPC_OP_IMM);
            M_SRLI:   p = pf(c_MASK_F7,  c_F7_BASE, 3'd5, c_OPC_OP_IMM);
            M_SRAI:   p = pf(c_MASK_F7,  c_F7_ALT,  3'd5, c_OPC_OP_IMM);
            M_ADD:    p = pf(c_MASK_F7,  c_F7_BASE, 3'd0, c_OPC_OP);
            M_SUB:    p = pf(c_MASK_F7,  c_F7_ALT,  3'd0, c_OPC_OP);
            M_SLL:    p = pf(c_MASK_F7,  c_F7_BASE, 3'd1, c_OPC_OP);
            M_SLT:    p = pf(c_MASK_F7,  c_F7_BASE, 3'd2, c_OPC_OP);
            M_SLTU:   p = pf(c_MASK_F7,  c_F7_BASE, 3'd3, c_OPC_OP);
            M_XOR:    p = pf(c_MASK_F7,  c_F7_BASE, 3'd4, c_OPC_OP);
            M_SRL:    p = pf(c_MASK_F7,  c_F7_BASE, 3'd5, c_OPC_OP);
            M_SRA:    p = pf(c_MASK_F7,  c_F7_ALT,  3'd5, c_OPC_OP);
            M_OR:     p = pf(c_MASK_F7,  c_F7_BASE, 3'd6, c_OPC_OP);
            M_AND:    p = pf(c_MASK_F7,  c_F7_BASE, 3'd7, c_OPC_OP);
            M_MUL:    p = pf(c_MASK_F7,  c_F7_MULDIV, 3'd0, c_OPC_OP);
            M_MULH:   p = pf(c_MASK_F7,  c_F7_MULDIV, 3'd1, c_OPC_OP);
            M_MULHSU: p = pf(c_MASK_F7,  c_F7_MULDIV, 3'd2, c_OPC_OP);
            M_MULHU:  p = pf(c_MASK_F7,  c_F7_MULDIV, 3'd3, c_OPC_OP);
            M_DIV:    p = pf(c_MASK_F7,  c_F7_MULDIV, 3'd4, c_OPC_OP);
            M_DIVU:   p = pf(c_MASK_F7,  c_F7_MULDIV, 3'd5, c_OPC_OP);
            M_REM:    p = pf(c_MASK_F7,  c_F7_MULDIV, 3'd6, c_OPC_OP);
            M_REMU:   p = pf(c_MASK_F7,  c_F7_MULDIV, 3'd7, c_OPC_OP);
            M_HALT:   begin p.mask = c_MASK_ALL; p.match = HALT; end
            default:  begin p.mask = '0; p.match = 32'h1; end
        endcase
        return p;
    endfunction

    function automatic instruction_t encode_rtype(input opcode_mask_t op, input logic [4:0] rd,
                                                  input logic [4:0] rs1, input logic [4:0] rs2);
        op_pattern_t p;
        p = op_pattern(op);
        return p.match | {7'b0, rs2, rs1, 3'b0, rd, 7'b0};
    endfunction

    function automatic instruction_t encode_itype(input opcode_mask_t op, input logic [4:0] rd,
                                                  input logic [4:0] rs1, input logic [11:0] imm);
        op_pattern_t p;
        p = op_pattern(op);
        return p.match | {imm, rs1, 3'b0, rd, 7'b0};
    endfunction

endpackage

`default_nettype wire

// File: rtl/instr_decode_stage_comb.sv
//==============================================================================
// Module : instr_decode_comb
// Brief  : Pure combinational instruction_t -> decoded_instr_t decoder.
// Config : RV32M_EN enables the multiply/divide group on the OP opcode.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module instr_decode_comb
    import instr_decode_stage_pkg::*;
#(
    parameter int XLEN = c_XLEN,
    parameter int PC_W = c_PC_W
) (
    input  logic [31:0]     instr,
    input  logic [PC_W-1:0] pc,
    output decoded_instr_t  dec
);

`ifdef RV32M_EN
    localparam bit c_M_EN = 1'b1;
`else
    localparam bit c_M_EN = 1'b0;
`endif

    instr_fmt_e        w_fmt;
    opcode_mask_t      w_op;
    op_pattern_t       w_pat;
    logic              w_found;
    logic              w_is_m;
    logic [XLEN-1:0]   w_imm;

    always_comb begin
        case (instr[6:0])
            c_OPC_OP:                                               w_fmt = FMT_R;
            c_OPC_OP_IMM, c_OPC_LOAD, c_OPC_JALR, c_OPC_SYSTEM:     w_fmt = FMT_I;
            c_OPC_STORE:                                            w_fmt = FMT_S;
            c_OPC_BRANCH:                                           w_fmt = FMT_B;
            c_OPC_LUI, c_OPC_AUIPC:                                 w_fmt = FMT_U;
            c_OPC_JAL:                                              w_fmt = FMT_J;
            default:                                                w_fmt = FMT_R;
        endcase
    end

    // Priority search of the mask/match table; the earliest entry wins.
    always_comb begin
        w_op    = M_ILLEGAL;
        w_found = 1'b0;
        w_pat   = '0;
        w_is_m  = 1'b0;
        for (int i = 0; i < int'(M_ILLEGAL); i++) begin
            w_pat  = op_pattern(opcode_mask_t'(i[5:0]));
            w_is_m = (i >= int'(M_MUL)) && (i <= int'(M_REMU));
            if (!w_found && (c_M_EN || !w_is_m) && ((instr & w_pat.mask) == w_pat.match)) begin
                w_op    = opcode_mask_t'(i[5:0]);
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        case (w_fmt)
            FMT_I:   w_imm = XLEN'($signed(instr[31:20]));
            FMT_S:   w_imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            FMT_B:   w_imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            FMT_U:   w_imm = XLEN'($signed({instr[31:12], 12'b0}));
            FMT_J:   w_imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            default: w_imm = '0;
        endcase
    end

    always_comb begin
        dec         = '0;
        dec.op      = w_op;
        dec.fmt     = w_fmt;
        dec.rd      = (w_fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) ? instr[11:7]  : 5'd0;
        dec.rs1     = (w_fmt inside {FMT_R, FMT_I, FMT_S, FMT_B}) ? instr[19:15] : 5'd0;
        dec.rs2     = (w_fmt inside {FMT_R, FMT_S, FMT_B})        ? instr[24:20] : 5'd0;
        dec.imm     = w_imm;
        dec.pc      = pc;
        dec.illegal = (w_op == M_ILLEGAL);
        dec.halt    = (w_op == M_HALT);
    end

endmodule

`default_nettype wire

// File: rtl/instr_decode_stage.sv
//==============================================================================
// Module : instr_decode_stage
// Brief  : Registered decode stage between fetch and execute with a 2-entry
//          skid buffer and a RUN/HALTED tracker for the HALT instruction.
// Config : RV32M_EN (passed through to instr_decode_comb).
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module instr_decode_stage
    import instr_decode_stage_pkg::*;
#(
    parameter int XLEN = c_XLEN,
    parameter int PC_W = c_PC_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output decoded_instr_t  out_dec,
    output logic            halted
);

    localparam logic [0:0] S_RUN    = 1'b0;
    localparam logic [0:0] S_HALTED = 1'b1;

    logic [0:0]     r_state;
    logic [0:0]     w_state_nxt;
    decoded_instr_t w_new;
    decoded_instr_t r_main;
    decoded_instr_t r_skid;
    logic           r_main_valid;
    logic           r_skid_valid;
    logic           r_rdy_en;
    logic           w_run;
    logic           w_accept;
    logic           w_retire;

    instr_decode_comb #(
        .XLEN (XLEN),
        .PC_W (PC_W)
    ) u_decode (
        .instr (in_instr),
        .pc    (in_pc),
        .dec   (w_new)
    );

    assign w_accept = in_valid & in_ready & ~flush;
    assign w_retire = r_main_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN:    if (w_accept && w_new.halt) w_state_nxt = S_HALTED;
            S_HALTED: if (flush)                  w_state_nxt = S_RUN;
            default:                              w_state_nxt = S_RUN;
        endcase
    end

    // in_ready depends only on registers, so out_ready never reaches it combinationally.
    always_comb begin
        w_run    = (r_state == S_RUN);
        halted   = (r_state == S_HALTED);
        in_ready = r_rdy_en & ~r_skid_valid & w_run;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy_en <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
        end
    end

    // Skid only fills when main is held; it always drains into main first to keep order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main       <= '0;
            r_skid       <= '0;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_main_valid || w_retire) begin
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_main_valid <= w_accept;
                if (w_accept) begin
                    r_main <= w_new;
                end
            end
        end else if (w_accept) begin
            r_skid       <= w_new;
            r_skid_valid <= 1'b1;
        end
    end

    assign out_valid = r_main_valid;
    assign out_dec   = r_main;

endmodule

`default_nettype wire

// File: tb/tb_instr_decode_stage.sv
//==============================================================================
// Module : tb_instr_decode_stage
// Brief  : Directed and randomized bench for instr_decode_stage against a
//          queue-based reference of the decode stage.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_instr_decode_stage;
    import instr_decode_stage_pkg::*;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           flush;
    logic           in_valid;
    logic           in_ready;
    logic [31:0]    in_instr;
    logic [31:0]    in_pc;
    logic           out_valid;
    logic           out_ready;
    decoded_instr_t out_dec;
    logic           halted;

    int n_checks = 0;
    int n_fail   = 0;
    int n_retired = 0;
    int n_halt_seen = 0;
    bit last_accept = 1'b0;

    decoded_instr_t exp_q[$];
    bit m_halt = 1'b0;
    bit m_rdy  = 1'b0;

    instr_decode_stage #(.XLEN(32), .PC_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_dec   (out_dec),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no end of test, expected finish within 1ms");
        $fatal(1, "timeout");
    end

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_dec(input string tag, input decoded_instr_t obs, input decoded_instr_t exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference decoder written from the instruction-set field rules.
    function automatic decoded_instr_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
        decoded_instr_t d;
        logic [6:0] opc, f7;
        logic [2:0] f3;
        opc = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
        d = '0; d.pc = pc; d.op = M_ILLEGAL; d.fmt = FMT_R;
        case (opc)
            7'h37: begin d.fmt = FMT_U; d.op = M_LUI;   d.imm = {i[31:12], 12'b0}; end
            7'h17: begin d.fmt = FMT_U; d.op = M_AUIPC; d.imm = {i[31:12], 12'b0}; end
            7'h6F: begin d.fmt = FMT_J; d.op = M_JAL;
                         d.imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0}; end
            7'h67: begin d.fmt = FMT_I; d.imm = {{20{i[31]}}, i[31:20]};
                         if (f3 == 3'd0) d.op = M_JALR; end
            7'h63: begin d.fmt = FMT_B; d.imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
                case (f3)
                    3'd0: d.op = M_BEQ;  3'd1: d.op = M_BNE;  3'd4: d.op = M_BLT;
                    3'd5: d.op = M_BGE;  3'd6: d.op = M_BLTU; 3'd7: d.op = M_BGEU;
                    default: d.op = M_ILLEGAL;
                endcase
            end
            7'h03: begin d.fmt = FMT_I; d.imm = {{20{i[31]}}, i[31:20]};
                case (f3)
                    3'd0: d.op = M_LB; 3'd1: d.op = M_LH; 3'd2: d.op = M_LW;
                    3'd4: d.op = M_LBU; 3'd5: d.op = M_LHU;
                    default: d.op = M_ILLEGAL;
                endcase
            end
            7'h23: begin d.fmt = FMT_S; d.imm = {{20{i[31]}}, i[31:25], i[11:7]};
                case (f3)
                    3'd0: d.op = M_SB; 3'd1: d.op = M_SH; 3'd2: d.op = M_SW;
                    default: d.op = M_ILLEGAL;
                endcase
            end
            7'h13: begin d.fmt = FMT_I; d.imm = {{20{i[31]}}, i[31:20]};
                case (f3)
                    3'd0: d.op = M_ADDI; 3'd2: d.op = M_SLTI; 3'd3: d.op = M_SLTIU;
                    3'd4: d.op = M_XORI; 3'd6: d.op = M_ORI;  3'd7: d.op = M_ANDI;
                    3'd1: d.op = (f7 == 7'h00) ? M_SLLI : M_ILLEGAL;
                    3'd5: d.op = (f7 == 7'h00) ? M_SRLI : (f7 == 7'h20) ? M_SRAI : M_ILLEGAL;
                    default: d.op = M_ILLEGAL;
                endcase
            end
            7'h33: begin
                if (f7 == 7'h00) begin
                    case (f3)
                        3'd0: d.op = M_ADD; 3'd1: d.op = M_SLL; 3'd2: d.op = M_SLT;
                        3'd3: d.op = M_SLTU; 3'd4: d.op = M_XOR; 3'd5: d.op = M_SRL;
                        3'd6: d.op = M_OR;  default: d.op = M_AND;
                    endcase
                end else if (f7 == 7'h20) begin
                    if (f3 == 3'd0) d.op = M_SUB;
                    else if (f3 == 3'd5) d.op = M_SRA;
                end
`ifdef RV32M_EN
                else if (f7 == 7'h01) begin
                    case (f3)
                        3'd0: d.op = M_MUL;  3'd1: d.op = M_MULH; 3'd2: d.op = M_MULHSU;
                        3'd3: d.op = M_MULHU; 3'd4: d.op = M_DIV; 3'd5: d.op = M_DIVU;
                        3'd6: d.op = M_REM;  default: d.op = M_REMU;
                    endcase
                end
`endif
            end
            7'h73: begin d.fmt = FMT_I; d.imm = {{20{i[31]}}, i[31:20]};
                         if (i == 32'h0010_0073) d.op = M_HALT; end
            default: d.fmt = FMT_R;
        endcase
        if (d.fmt == FMT_R || d.fmt == FMT_I || d.fmt == FMT_U || d.fmt == FMT_J) d.rd  = i[11:7];
        if (d.fmt == FMT_R || d.fmt == FMT_I || d.fmt == FMT_S || d.fmt == FMT_B) d.rs1 = i[19:15];
        if (d.fmt == FMT_R || d.fmt == FMT_S || d.fmt == FMT_B)                   d.rs2 = i[24:20];
        d.illegal = (d.op == M_ILLEGAL);
        d.halt    = (d.op == M_HALT);
        return d;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          sel;
        logic [6:0]  opcs [10];
        logic [6:0]  f7s [3];
        opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
        f7s  = '{7'h00, 7'h20, 7'h01};
        w   = $urandom;
        sel = $urandom_range(0, 15);
        if (sel == 0) begin
            w = 32'h0010_0073;
        end else if (sel > 2) begin
            w[6:0] = opcs[$urandom_range(0, 9)];
            if (w[6:0] == 7'h33 || w[6:0] == 7'h13) w[31:25] = f7s[$urandom_range(0, 2)];
        end
        return w;
    endfunction

    // Compare outputs against the queue model, then advance one clock.
    task automatic cycle();
        logic exp_rdy, exp_ov, acc, ret, fl;
        logic [31:0] ins, pc;
        decoded_instr_t tmp;
        exp_rdy = m_rdy && !m_halt && (exp_q.size() < 2);
        exp_ov  = (exp_q.size() > 0);
        chk_bit("in_ready", in_ready, exp_rdy);
        chk_bit("out_valid", out_valid, exp_ov);
        chk_bit("halted", halted, m_halt);
        if (exp_ov) chk_dec("out_dec", out_dec, exp_q[0]);
        if (out_valid && out_ready) n_retired++;
        if (out_valid && out_ready && out_dec.halt) n_halt_seen++;
        fl  = flush;
        ins = in_instr;
        pc  = in_pc;
        acc = in_valid && exp_rdy && !fl;
        ret = exp_ov && out_ready;
        last_accept = acc;
        @(posedge clk);
        #1;
        if (fl) begin
            exp_q.delete();
            m_halt = 1'b0;
        end else begin
            if (ret) tmp = exp_q.pop_front();
            if (acc) begin
                exp_q.push_back(ref_decode(ins, pc));
                if (ins == 32'h0010_0073) m_halt = 1'b1;
            end
        end
        m_rdy = 1'b1;
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] pc, input int budget, output bit ok);
        ok       = 1'b0;
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc;
        for (int n = 0; n < budget && !ok; n++) begin
            cycle();
            ok = last_accept;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        bit ok;
        int r0, h0;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;

        #1;
        chk_bit("rst_out_valid", out_valid, 1'b0);
        chk_bit("rst_in_ready", in_ready, 1'b0);
        chk_bit("rst_halted", halted, 1'b0);
        chk_dec("rst_out_dec", out_dec, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_rdy = 1'b0;
        cycle();

        // ADD then ADDI, full throughput
        out_ready = 1'b1;
        send(32'h0031_00B3, 32'h100, 3, ok);
        chk_bit("t1_sent", ok, 1'b1);
        chk_word("t1_op", 32'(out_dec.op), 32'(M_ADD));
        chk_word("t1_fmt", 32'(out_dec.fmt), 32'(FMT_R));
        chk_word("t1_regs", {17'b0, out_dec.rd, out_dec.rs1, out_dec.rs2}, {17'b0, 5'd1, 5'd2, 5'd3});
        chk_word("t1_imm", out_dec.imm, 32'h0);
        send(32'hFFF0_0293, 32'h104, 3, ok);
        chk_word("t2_op", 32'(out_dec.op), 32'(M_ADDI));
        chk_word("t2_rd_rs1", {22'b0, out_dec.rd, out_dec.rs1}, {22'b0, 5'd5, 5'd0});
        chk_word("t2_imm", out_dec.imm, 32'hFFFF_FFFF);
        chk_bit("t2_illegal", out_dec.illegal, 1'b0);
        cycle();

        // Stalled output: two accepted, third blocked, then all three drain in order
        out_ready = 1'b0;
        r0 = n_retired;
        send(encode_itype(M_LW, 5'd7, 5'd8, 12'h804), 32'h200, 3, ok);
        send(32'h0000_0463, 32'h204, 3, ok);
        send(32'h0080_00EF, 32'h208, 1, ok);
        chk_bit("t3_third_blocked", ok, 1'b0);
        chk_bit("t3_full", in_ready, 1'b0);
        out_ready = 1'b1;
        send(32'h0080_00EF, 32'h208, 4, ok);
        chk_bit("t3_third_sent", ok, 1'b1);
        for (int n = 0; n < 6 && exp_q.size() > 0; n++) cycle();
        chk_word("t3_retired", 32'(n_retired - r0), 32'd3);

        // HALT blocks later instructions until flush
        h0 = n_halt_seen;
        send(encode_rtype(M_SUB, 5'd4, 5'd5, 5'd6), 32'h300, 3, ok);
        chk_word("t4_sub_op", 32'(out_dec.op), 32'(M_SUB));
        send(HALT, 32'h304, 3, ok);
        send(32'h0031_00B3, 32'h308, 4, ok);
        chk_bit("t4_add_blocked", ok, 1'b0);
        chk_bit("t4_halted", halted, 1'b1);
        chk_word("t4_halt_out", 32'(n_halt_seen - h0), 32'd1);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk_bit("t4_unhalted", halted, 1'b0);
        chk_bit("t4_ready", in_ready, 1'b1);

        // Multiply encoding on OP
        send(32'h0231_00B3, 32'h400, 3, ok);
`ifdef RV32M_EN
        chk_word("t5_op", 32'(out_dec.op), 32'(M_MUL));
        chk_bit("t5_illegal", out_dec.illegal, 1'b0);
`else
        chk_word("t5_op", 32'(out_dec.op), 32'(M_ILLEGAL));
        chk_bit("t5_illegal", out_dec.illegal, 1'b1);
`endif
        cycle();

        // Flush wins over a same-cycle input
        out_ready = 1'b0;
        send(32'h0031_00B3, 32'h500, 3, ok);
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'hFFF0_0293;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        chk_bit("flush_empty", out_valid, 1'b0);

        // Asynchronous reset with main and skid both occupied
        send(32'h0031_00B3, 32'h600, 3, ok);
        send(32'hFFF0_0293, 32'h604, 3, ok);
        chk_bit("t6_full", in_ready, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_bit("t6_out_valid", out_valid, 1'b0);
        chk_bit("t6_in_ready", in_ready, 1'b0);
        chk_dec("t6_out_dec", out_dec, '0);
        exp_q.delete();
        m_halt = 1'b0;
        m_rdy  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        cycle();

        for (int k = 0; k < 600; k++) begin
            flush     = ($urandom_range(0, 19) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_instr  = rand_instr();
            in_pc     = $urandom;
            cycle();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int n = 0; n < 4; n++) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
